npu_seq_ctrl: RTL and testbench
===============================

Name: npu_seq_ctrl

Overview:
Inference sequencer for the NPU top. On a host trigger it runs conv1, then conv2, then the FC engine, and latches the signed 24-bit logit. It buffers host-written FC1 weight groups (NUM_PE bytes per write) in a small FIFO and serves them to the FC engine on its request/valid handshake. A per-phase watchdog catches a stalled datapath and drives an error state.

Parameters:
NUM_PE, 4, weight bytes per FC1 group (one host word)
IN1_N, 132, FC1 input vector length
OUT1_M, 10, FC1 output count
WQ_DEPTH, 8, weight FIFO depth in groups (power of 2, >=2)
TIMEOUT_CYC, 4096, watchdog limit in cycles without progress

Ports:
clk  in  1  clock
rst_ni  in  1  asynchronous active-low reset
host_trigger  in  1  start pulse
host_abort  in  1  abort/clear pulse
wq_push  in  1  push one weight group
wq_data  in  NUM_PE*8  group; byte p = bits [8p+7:8p]
wq_full  out  1  FIFO full
conv1_start  out  1  1-cycle start pulse to conv1
conv1_done  in  1  conv1 completion pulse
conv2_start  out  1  1-cycle start pulse to conv2
conv2_done  in  1  conv2 completion pulse
fcn_start  out  1  1-cycle start pulse to FC engine
fcn_fc1_next  in  1  FC engine requests the next group
fcn_fc1_valid  out  1  group valid on fcn_w_stream
fcn_w_stream  out  NUM_PE*8  weight group to FC engine
fcn_done  in  1  FC completion pulse
fcn_logit  in  24  signed logit
busy  out  1  state not IDLE/ERR
done_pulse  out  1  1-cycle inference-complete pulse
result  out  24  last latched logit, signed
status  out  8  [2:0] state code, [3] overflow, [4] protocol error, [5] group mismatch, [6] timeout, [7] FIFO empty
perf_cycles  out  32  see Optional Feature

Behaviour:
- Reset is asynchronous and active-low on rst_ni. All outputs and flags reset to 0, except status[7]=1. State resets to IDLE. FIFO is empty; fcn_w_stream=0.
- TOTAL_GROUPS = IN1_N*OUT1_M/NUM_PE (330 at defaults). The group counter is 10 bits minimum, sized by $clog2(TOTAL_GROUPS+1).
- State codes: IDLE=0, CONV1=1, CONV2=2, FC_RUN=3, DONE=4, ERR=5.
- IDLE: host_trigger -> CONV1. conv1_start=1 in the cycle after the trigger is sampled. Sticky flags [3..6] clear on that trigger.
- CONV1: conv1_done -> CONV2, with a conv2_start pulse the next cycle.
- CONV2: conv2_done -> FC_RUN, with a fcn_start pulse the next cycle. The group counter and pending-request flag clear.
- FC_RUN request handling:
  - fcn_fc1_next sets pending_req.
  - If pending_req is already set, a new fcn_fc1_next sets sticky protocol error [4]; the request is not queued twice.
  - When pending_req=1 and the FIFO is non-empty: pop, register the head onto fcn_w_stream, pulse fcn_fc1_valid for 1 cycle, clear pending_req, increment the group counter.
  - Minimum latency fcn_fc1_next -> fcn_fc1_valid is 1 cycle.
  - fcn_w_stream holds its value between pops.
- FC_RUN completion: fcn_done -> latch fcn_logit into result, go to DONE. If the group counter != TOTAL_GROUPS at fcn_done, set [5].
- DONE: done_pulse=1 for exactly 1 cycle -> IDLE.
- Watchdog:
  - Resets on each state entry, on any done input, and on each fcn_fc1_valid.
  - Reaching TIMEOUT_CYC in CONV1, CONV2 or FC_RUN -> ERR and sets [6].
  - FIFO starvation counts toward the timeout.
- ERR: outputs idle and busy=0. Only host_abort exits.
- host_abort, any state: next cycle is IDLE; FIFO flushed; pending_req and sticky flags cleared; result kept. Abort has priority over trigger and all done inputs in the same cycle.
- FIFO:
  - Push is accepted when not full, or when a pop occurs in the same cycle.
  - A rejected push sets [3] and the data is dropped.
  - Pushes are accepted in every state, so the host may preload before triggering. Pops occur only in FC_RUN.
  - wq_full and status[7] are registered from the occupancy count; pointers wrap modulo WQ_DEPTH.
- Ignored inputs (no effect): host_trigger while busy or in ERR; done inputs outside their own state.

Optional Feature:
NPU_SEQ_CTRL_PERF_EN:
- Defined: a 32-bit counter runs from CONV1 entry to DONE entry, saturating at 2^32-1. It is copied to perf_cycles on DONE entry and unchanged on abort or ERR.
- Undefined: perf_cycles is tied to 0 and no counter is built.

Test Plan:
- Preload 8 groups, trigger, conv1_done at +5, conv2_done at +5, then fcn_fc1_next every 4 cycles with host refill to 330 groups, fcn_done with logit 24'hFFFF38 -> result=-200, done_pulse once, status[5:3]=0, each fcn_fc1_valid 1 cycle after its request.
- 9 pushes into an empty FIFO with no pop -> wq_full after 8, 9th push dropped, status[3]=1.
- fcn_done after 100 groups -> status[5]=1, result latched, DONE->IDLE.
- Never assert conv2_done -> ERR exactly TIMEOUT_CYC cycles after CONV2 entry, status[6]=1; trigger ignored; host_abort -> IDLE, flags clear.
- Two fcn_fc1_next pulses with FIFO empty -> status[4]=1; one push -> exactly one fcn_fc1_valid.
- rst_ni low mid-FC_RUN -> all outputs 0 immediately, status[7]=1; with the macro defined, a normal run gives perf_cycles equal to the cycle count from CONV1 entry to DONE entry.

Source files
------------

// File: rtl/npu_seq_ctrl_if.sv
// Host, datapath and weight-stream signals of the NPU inference sequencer.
// master = host/datapath side, slave = sequencer.
interface npu_seq_ctrl_if #(
  parameter int NUM_PE = 4
);
  logic                  host_trigger;
  logic                  host_abort;
  logic                  wq_push;
  logic [NUM_PE*8-1:0]   wq_data;
  logic                  wq_full;
  logic                  conv1_start;
  logic                  conv1_done;
  logic                  conv2_start;
  logic                  conv2_done;
  logic                  fcn_start;
  logic                  fcn_fc1_next;
  logic                  fcn_fc1_valid;
  logic [NUM_PE*8-1:0]   fcn_w_stream;
  logic                  fcn_done;
  logic [23:0]           fcn_logit;
  logic                  busy;
  logic                  done_pulse;
  logic [23:0]           result;
  logic [7:0]            status;
  logic [31:0]           perf_cycles;

  modport master (
    output host_trigger, host_abort, wq_push, wq_data,
    output conv1_done, conv2_done, fcn_fc1_next, fcn_done, fcn_logit,
    input  wq_full, conv1_start, conv2_start, fcn_start,
    input  fcn_fc1_valid, fcn_w_stream, busy, done_pulse, result, status, perf_cycles
  );

  modport slave (
    input  host_trigger, host_abort, wq_push, wq_data,
    input  conv1_done, conv2_done, fcn_fc1_next, fcn_done, fcn_logit,
    output wq_full, conv1_start, conv2_start, fcn_start,
    output fcn_fc1_valid, fcn_w_stream, busy, done_pulse, result, status, perf_cycles
  );
endinterface

// File: rtl/npu_seq_ctrl.sv
// NPU inference sequencer: conv1 -> conv2 -> FC, FC1 weight FIFO and per-phase watchdog.
// Define NPU_SEQ_CTRL_PERF_EN to build the CONV1-to-DONE cycle counter on perf_cycles.
//
// state  | meaning
// IDLE   | waiting for host_trigger
// CONV1  | conv1 running, waiting conv1_done
// CONV2  | conv2 running, waiting conv2_done
// FC_RUN | FC engine running, serving weight groups, waiting fcn_done
// DONE   | one-cycle completion pulse
// ERR    | watchdog expired, held until host_abort
module npu_seq_ctrl #(
  parameter int NUM_PE      = 4,
  parameter int IN1_N       = 132,
  parameter int OUT1_M      = 10,
  parameter int WQ_DEPTH    = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic         clk,
  input logic         rst_ni,
  npu_seq_ctrl_if.slave bus
);

  localparam int GW           = NUM_PE * 8;
  localparam int TOTAL_GROUPS = IN1_N * OUT1_M / NUM_PE;
  localparam int GC_W         = ($clog2(TOTAL_GROUPS + 1) > 10) ? $clog2(TOTAL_GROUPS + 1) : 10;
  localparam int PTR_W        = $clog2(WQ_DEPTH);
  localparam int CNT_W        = $clog2(WQ_DEPTH + 1);
  localparam int WD_W         = $clog2(TIMEOUT_CYC + 1);

  localparam logic [GC_W-1:0]  GC_TOTAL = GC_W'(TOTAL_GROUPS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WQ_DEPTH);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONV1  = 3'd1,
    CONV2  = 3'd2,
    FC_RUN = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [GW-1:0]    mem [WQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] wq_cnt, wq_cnt_nxt;
  logic             wq_empty_r, wq_full_r;

  logic             pending_req;
  logic [GC_W-1:0]  grp_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic             flg_ovf, flg_proto, flg_mism, flg_tmo;
  logic [23:0]      result_r;
  logic [GW-1:0]    w_stream_r;
  logic             valid_r, conv1_start_r, conv2_start_r, fcn_start_r;

  logic abort, start_run, fc_finish, in_watch, any_done, progress;
  logic pop, push_ok, push_drop, proto_err, timeout, flag_clr, enter_fc;

  assign abort    = bus.host_abort;
  assign any_done = bus.conv1_done | bus.conv2_done | bus.fcn_done;

  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    fc_finish = 1'b0;
    pop       = 1'b0;
    proto_err = 1'b0;
    in_watch  = (state == CONV1) || (state == CONV2) || (state == FC_RUN);
    if ((state == FC_RUN) && !abort) begin
      // a request is served in the cycle it arrives when a group is already queued
      pop       = (pending_req || bus.fcn_fc1_next) && !wq_empty_r;
      proto_err = pending_req && bus.fcn_fc1_next;
    end
    push_ok   = bus.wq_push && !abort && (!wq_full_r || pop);
    push_drop = bus.wq_push && !abort && !push_ok;
    progress  = any_done || pop;
    timeout   = in_watch && !abort && (wd_cnt == '0) && !progress;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.host_trigger) begin
          state_nxt = CONV1;
          start_run = 1'b1;
        end
        CONV1: begin
          if (bus.conv1_done)   state_nxt = CONV2;
          else if (timeout)     state_nxt = ERR;
        end
        CONV2: begin
          if (bus.conv2_done)   state_nxt = FC_RUN;
          else if (timeout)     state_nxt = ERR;
        end
        FC_RUN: begin
          if (bus.fcn_done) begin
            state_nxt = DONE;
            fc_finish = 1'b1;
          end else if (timeout) begin
            state_nxt = ERR;
          end
        end
        DONE:    state_nxt = IDLE;
        ERR:     state_nxt = ERR;
        default: state_nxt = IDLE;
      endcase
    end
    flag_clr = abort || start_run;
    enter_fc = (state == CONV2) && (state_nxt == FC_RUN);
    case ({push_ok, pop})
      2'b10:   wq_cnt_nxt = wq_cnt + CNT_W'(1);
      2'b01:   wq_cnt_nxt = wq_cnt - CNT_W'(1);
      default: wq_cnt_nxt = wq_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.wq_data;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wq_cnt     <= '0;
      wq_empty_r <= 1'b1;
      wq_full_r  <= 1'b0;
    end else if (abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wq_cnt     <= '0;
      wq_empty_r <= 1'b1;
      wq_full_r  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      wq_cnt     <= wq_cnt_nxt;
      wq_empty_r <= (wq_cnt_nxt == '0);
      wq_full_r  <= (wq_cnt_nxt == CNT_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      conv1_start_r <= 1'b0;
      conv2_start_r <= 1'b0;
      fcn_start_r   <= 1'b0;
      valid_r       <= 1'b0;
      w_stream_r    <= '0;
      pending_req   <= 1'b0;
      grp_cnt       <= '0;
      wd_cnt        <= WD_LOAD;
      result_r      <= '0;
      flg_ovf       <= 1'b0;
      flg_proto     <= 1'b0;
      flg_mism      <= 1'b0;
      flg_tmo       <= 1'b0;
    end else begin
      state         <= state_nxt;
      conv1_start_r <= start_run;
      conv2_start_r <= (state == CONV1) && (state_nxt == CONV2);
      fcn_start_r   <= enter_fc;
      valid_r       <= pop;
      if (pop) w_stream_r <= mem[rd_ptr];

      if (abort || enter_fc || pop)                  pending_req <= 1'b0;
      else if ((state == FC_RUN) && bus.fcn_fc1_next) pending_req <= 1'b1;

      if (enter_fc) grp_cnt <= '0;
      else if (pop) grp_cnt <= grp_cnt + GC_W'(1);

      if ((state_nxt != state) || progress) wd_cnt <= WD_LOAD;
      else if (in_watch && (wd_cnt != '0))  wd_cnt <= wd_cnt - WD_W'(1);

      if (fc_finish) result_r <= bus.fcn_logit;

      flg_ovf   <= (flg_ovf   && !flag_clr) || push_drop;
      flg_proto <= (flg_proto && !flag_clr) || proto_err;
      flg_mism  <= (flg_mism  && !flag_clr) || (fc_finish && (grp_cnt != GC_TOTAL));
      flg_tmo   <= (flg_tmo   && !flag_clr) || ((state_nxt == ERR) && (state != ERR));
    end
  end

`ifdef NPU_SEQ_CTRL_PERF_EN
  logic [31:0] perf_cnt, perf_r;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cnt <= '0;
      perf_r   <= '0;
    end else begin
      if (start_run)                          perf_cnt <= '0;
      else if (in_watch && (perf_cnt != '1))  perf_cnt <= perf_cnt + 32'd1;
      // count includes the final FC_RUN cycle, so DONE entry reports entry-to-entry distance
      if (fc_finish) perf_r <= (perf_cnt == '1) ? perf_cnt : perf_cnt + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_r;
`else
  assign bus.perf_cycles = '0;
`endif

  assign bus.wq_full       = wq_full_r;
  assign bus.conv1_start   = conv1_start_r;
  assign bus.conv2_start   = conv2_start_r;
  assign bus.fcn_start     = fcn_start_r;
  assign bus.fcn_fc1_valid = valid_r;
  assign bus.fcn_w_stream  = w_stream_r;
  assign bus.busy          = (state != IDLE) && (state != ERR);
  assign bus.done_pulse    = (state == DONE);
  assign bus.result        = result_r;
  assign bus.status        = {wq_empty_r, flg_tmo, flg_mism, flg_proto, flg_ovf, state};

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Scoreboard bench for npu_seq_ctrl: stimulus queues expected weight groups and
// completion records; a negedge monitor pops and compares whenever the DUT presents them.
module tb_npu_seq_ctrl;
  localparam int TOUT = 4096;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  npu_seq_ctrl_if #(.NUM_PE(4)) bus ();

  npu_seq_ctrl #(
    .NUM_PE(4), .IN1_N(132), .OUT1_M(10), .WQ_DEPTH(8), .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk(clk),
    .rst_ni(rst_ni),
    .bus(bus)
  );

  typedef struct { logic [31:0] d; int c; } w_exp_t;
  typedef struct { logic [23:0] r; logic [7:0] s; } d_exp_t;
  w_exp_t      exp_w[$];
  d_exp_t      exp_d[$];
  logic [31:0] model_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] gdat(input int i);
    return (32'(i) * 32'h01030507) ^ 32'h5A000000;
  endfunction

  // monitor: every presented group / completion must match the head of its queue
  always @(negedge clk) begin
    if (rst_ni) begin
      if (bus.fcn_fc1_valid) begin
        if (exp_w.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL valid_unexpected: got data %h with no pending request", bus.fcn_w_stream);
        end else begin
          w_exp_t e;
          e = exp_w.pop_front();
          chk("w_stream", bus.fcn_w_stream, e.d);
          chk("valid_cycle", 32'(cyc), 32'(e.c));
        end
      end
      if (bus.done_pulse) begin
        if (exp_d.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL done_unexpected: got result %h with no completion expected", bus.result);
        end else begin
          d_exp_t e;
          e = exp_d.pop_front();
          chk("done_result", 32'(bus.result), 32'(e.r));
          chk("done_status", 32'(bus.status), 32'(e.s));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int pushed = 0;

  task automatic push(input logic [31:0] d, input bit to_model);
    bus.wq_push = 1'b1; bus.wq_data = d;
    if (to_model) model_q.push_back(d);
    tick();
    bus.wq_push = 1'b0;
  endtask

  task automatic start_to_fc();
    bus.host_trigger = 1'b1; tick(); bus.host_trigger = 1'b0;
    chk("conv1_start", 32'(bus.conv1_start), 32'd1);
    chk("state_conv1", 32'(bus.status[2:0]), 32'd1);
    chk("flags_clear", 32'(bus.status[6:3]), 32'd0);
    repeat (4) tick();
    bus.conv1_done = 1'b1; tick(); bus.conv1_done = 1'b0;
    chk("conv2_start", 32'(bus.conv2_start), 32'd1);
    repeat (4) tick();
    bus.conv2_done = 1'b1; tick(); bus.conv2_done = 1'b0;
    chk("fcn_start", 32'(bus.fcn_start), 32'd1);
    chk("state_fc", 32'(bus.status[2:0]), 32'd3);
  endtask

  // one request every 4 cycles, refilled by the host up to 'total' groups
  task automatic run_groups(input int n, input int total);
    for (int g = 0; g < n; g++) begin
      w_exp_t e;
      bus.fcn_fc1_next = 1'b1;
      e.d = model_q.pop_front();
      e.c = cyc + 1;
      exp_w.push_back(e);
      if (pushed < total) begin
        bus.wq_push = 1'b1; bus.wq_data = gdat(pushed);
        model_q.push_back(gdat(pushed));
        pushed++;
      end
      tick();
      bus.fcn_fc1_next = 1'b0; bus.wq_push = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic finish_fc(input logic [23:0] logit, input logic [7:0] st);
    d_exp_t e;
    e.r = logit; e.s = st;
    exp_d.push_back(e);
    bus.fcn_done = 1'b1; bus.fcn_logit = logit;
    tick();
    bus.fcn_done = 1'b0;
    tick();
  endtask

  task automatic abort();
    bus.host_abort = 1'b1; tick(); bus.host_abort = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int t_trig, t_done, n_conv2, t_err;
    bit found;
    logic [31:0] x;

    bus.host_trigger = 0; bus.host_abort = 0; bus.wq_push = 0; bus.wq_data = '0;
    bus.conv1_done = 0; bus.conv2_done = 0; bus.fcn_fc1_next = 0;
    bus.fcn_done = 0; bus.fcn_logit = '0;
    #12;
    chk("rst_status", 32'(bus.status), 32'h80);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_w_stream", bus.fcn_w_stream, 32'd0);
    rst_ni = 1'b1;
    tick();

    // full inference with preload and refill to 330 groups
    pushed = 0;
    for (int i = 0; i < 8; i++) begin push(gdat(pushed), 1'b1); pushed++; end
    chk("preload_full", 32'(bus.wq_full), 32'd1);
    t_trig = cyc;
    start_to_fc();
    run_groups(330, 330);
    t_done = cyc;
    finish_fc(24'hFFFF38, 8'h84);
    chk("run1_result", 32'(bus.result), 32'h00FFFF38);
    chk("run1_idle", 32'(bus.status), 32'h80);
`ifdef NPU_SEQ_CTRL_PERF_EN
    chk("perf_cycles", bus.perf_cycles, 32'(t_done - t_trig));
`else
    chk("perf_cycles_tied", bus.perf_cycles, 32'd0);
`endif

    // overflow: 9 pushes into empty FIFO
    for (int i = 0; i < 7; i++) push(gdat(1000 + i), 1'b0);
    chk("not_full_7", 32'(bus.wq_full), 32'd0);
    push(gdat(1007), 1'b0);
    chk("full_8", 32'(bus.wq_full), 32'd1);
    push(gdat(1008), 1'b0);
    chk("ovf_status", 32'(bus.status), 32'h08);
    abort();
    chk("abort_flush", 32'(bus.status), 32'h80);
    chk("abort_full", 32'(bus.wq_full), 32'd0);

    // early fcn_done after 100 groups
    model_q.delete();
    pushed = 0;
    for (int i = 0; i < 8; i++) begin push(gdat(pushed), 1'b1); pushed++; end
    start_to_fc();
    run_groups(100, 100);
    finish_fc(24'h000123, 8'hA4);
    chk("mism_idle", 32'(bus.status), 32'hA0);
    chk("mism_result", 32'(bus.result), 32'h123);

    // watchdog in CONV2
    bus.host_trigger = 1'b1; tick(); bus.host_trigger = 1'b0;
    chk("trig_clears_mism", 32'(bus.status), 32'h81);
    repeat (4) tick();
    n_conv2 = cyc;
    bus.conv1_done = 1'b1; tick(); bus.conv1_done = 1'b0;
    found = 1'b0; t_err = 0;
    for (int i = 0; i < TOUT + 200 && !found; i++) begin
      if (bus.status[2:0] == 3'd5) begin found = 1'b1; t_err = cyc; end
      else tick();
    end
    chk("err_reached", 32'(found), 32'd1);
    chk("err_cycle", 32'(t_err), 32'(n_conv2 + 1 + TOUT));
    chk("err_status", 32'(bus.status), 32'hC5);
    chk("err_busy", 32'(bus.busy), 32'd0);
    bus.host_trigger = 1'b1; tick(); bus.host_trigger = 1'b0;
    chk("err_trig_ignored", 32'(bus.status), 32'hC5);
    abort();
    chk("err_abort", 32'(bus.status), 32'h80);
    chk("result_kept", 32'(bus.result), 32'h123);

    // protocol error, then one push serves the single pending request
    start_to_fc();
    bus.fcn_fc1_next = 1'b1; tick(); bus.fcn_fc1_next = 1'b0;
    bus.fcn_fc1_next = 1'b1; tick(); bus.fcn_fc1_next = 1'b0;
    chk("proto_status", 32'(bus.status), 32'h93);
    x = 32'hC0FFEE11;
    begin
      w_exp_t e;
      e.d = x; e.c = cyc + 2;
      exp_w.push_back(e);
    end
    push(x, 1'b0);
    repeat (6) tick();
    chk("proto_served", 32'(exp_w.size()), 32'd0);

    // async reset in FC_RUN
    push(32'h11223344, 1'b0);
    rst_ni = 1'b0;
    #2;
    chk("arst_status", 32'(bus.status), 32'h80);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_result", 32'(bus.result), 32'd0);
    chk("arst_w_stream", bus.fcn_w_stream, 32'd0);
    chk("arst_outs", 32'({bus.wq_full, bus.conv1_start, bus.conv2_start, bus.fcn_start,
                          bus.fcn_fc1_valid, bus.done_pulse}), 32'd0);
    chk("arst_perf", bus.perf_cycles, 32'd0);
    @(negedge clk); rst_ni = 1'b1;
    repeat (3) tick();

    chk("exp_w_drained", 32'(exp_w.size()), 32'd0);
    chk("exp_d_drained", 32'(exp_d.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
